// File: rtl/mc_ctrl_pkg.sv
// Package mc_ctrl_pkg
// Purpose: shared constants and types for the multicycle MIPS control unit:
//   opcode/funct encodings, ALU codes, datapath mux encodings, FSM state
//   enum and fault codes, plus the DECODE-stage dispatch helper.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned FAULT_W = 2;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_NONE = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 3'd5;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Sticky fault codes
    localparam logic [FAULT_W-1:0] FAULT_NONE    = 2'b00;
    localparam logic [FAULT_W-1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [FAULT_W-1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_REXEC,
        S_RWB,
        S_IEXEC,
        S_IWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_e;

    // State following DECODE for a given opcode; unknown opcodes go to FAULT.
    function automatic state_e decode_next(input logic [OP_W-1:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:               nxt = S_REXEC;
            OP_ADDI:                nxt = S_IEXEC;
            OP_LW, OP_SW:           nxt = S_MEMADR;
            OP_BEQ, OP_BNE, OP_BGTZ: nxt = S_BRANCH;
            OP_J:                   nxt = S_JUMP;
            default:                nxt = S_FAULT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_funct_dec.sv
// Module alu_funct_dec
// Purpose: combinational R-type funct decoder.
// Ports:
//   funct       in   FN_W   IR[5:0]
//   alucontrol  out  ALUCW  ALU operation code (0 when funct is not supported)
//   valid       out  1      funct is one of ADD/SUB/AND/OR/SLT
module alu_funct_dec
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCW = 3
) (
    input  logic [FN_W-1:0]  funct,
    output logic [ALUCW-1:0] alucontrol,
    output logic             valid
);

    always_comb begin
        alucontrol = '0;
        valid      = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALUCW'(ALU_ADD);
            FN_SUB:  alucontrol = ALUCW'(ALU_SUB);
            FN_AND:  alucontrol = ALUCW'(ALU_AND);
            FN_OR:   alucontrol = ALUCW'(ALU_OR);
            FN_SLT:  alucontrol = ALUCW'(ALU_SLT);
            default: valid      = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Module mc_ctrl_fsm
// Purpose: multicycle MIPS control unit. Moore FSM whose datapath strobes and
//   mux selects are decoded from the current state (plus ALU flags and
//   mem_ready). Handles R-type funct decode, beq/bne/bgtz resolution, a memory
//   ready handshake with timeout, sticky fault capture and a retire pulse.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   op, funct           instruction register fields
//   alu_zero, alu_neg   ALU result flags
//   mem_ready           memory completes current access this cycle
//   iord..pcsrc         datapath controls
//   retire              one-cycle pulse on instruction completion
//   fault               sticky fault code (01 illegal, 10 memory timeout)
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCW    = 3,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNTW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FN_W-1:0]    funct,
    input  logic               alu_zero,
    input  logic               alu_neg,
    input  logic               mem_ready,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUCW-1:0]   alucontrol,
    output logic [1:0]         pcsrc,
    output logic               retire,
    output logic [FAULT_W-1:0] fault
);

    // Counter value on the last permitted waiting cycle.
    localparam logic [CNTW-1:0] CNT_LAST = (WAIT_MAX == 0) ? '0 : CNTW'(WAIT_MAX - 1);

    state_e             state;
    logic [CNTW-1:0]    cnt;
    logic [FAULT_W-1:0] fault_q;
    logic [ALUCW-1:0]   fn_alu;
    logic               fn_valid;
    logic               timeout_c;

    alu_funct_dec #(
        .ALUCW (ALUCW)
    ) u_funct_dec (
        .funct      (funct),
        .alucontrol (fn_alu),
        .valid      (fn_valid)
    );

    // mem_ready in the final allowed cycle takes priority over the timeout.
    assign timeout_c = (WAIT_MAX != 0) && !mem_ready && (cnt == CNT_LAST);

    // State, wait counter and sticky fault register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_INIT;
            cnt     <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            // Counter only survives while stalled in a waiting state, so every
            // entry into FETCH/MEMRD/MEMWR sees it cleared.
            cnt <= '0;
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout_c) begin
                        state   <= S_FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_DECODE: begin
                    state <= decode_next(op);
                    if (decode_next(op) == S_FAULT) begin
                        fault_q <= FAULT_ILLEGAL;
                    end
                end
                S_REXEC: begin
                    if (fn_valid) begin
                        state <= S_RWB;
                    end else begin
                        state   <= S_FAULT;
                        fault_q <= FAULT_ILLEGAL;
                    end
                end
                S_IEXEC:  state <= S_IWB;
                S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ready) begin
                        state <= S_MEMWB;
                    end else if (timeout_c) begin
                        state   <= S_FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else if (timeout_c) begin
                        state   <= S_FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Output decode; everything is forced low while rst is high.
    always_comb begin
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        alucontrol = '0;
        pcsrc      = PCSRC_ALU;
        retire     = 1'b0;
        fault      = FAULT_NONE;
        if (!rst) begin
            fault = fault_q;
            case (state)
                S_FETCH: begin
                    memread    = 1'b1;
                    alusrcb    = SRCB_ONE;
                    alucontrol = ALUCW'(ALU_ADD);
                    irwrite    = mem_ready;
                    pcwrite    = mem_ready;
                end
                S_DECODE: begin
                    alusrcb    = SRCB_BOFF;
                    alucontrol = ALUCW'(ALU_ADD);
                end
                S_REXEC: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_RT;
                    alucontrol = fn_alu;
                end
                S_RWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_IEXEC, S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    alucontrol = ALUCW'(ALU_ADD);
                end
                S_IWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    retire   = mem_ready;
                end
                S_BRANCH: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_RT;
                    alucontrol = ALUCW'(ALU_SUB);
                    pcsrc      = PCSRC_ALUOUT;
                    retire     = 1'b1;
                    // bgtz compares rs against $0, so the SUB result is rs itself.
                    case (op)
                        OP_BEQ:  pcwrite = alu_zero;
                        OP_BNE:  pcwrite = !alu_zero;
                        OP_BGTZ: pcwrite = !alu_zero && !alu_neg;
                        default: pcwrite = 1'b0;
                    endcase
                end
                S_JUMP: begin
                    pcsrc   = PCSRC_JUMP;
                    pcwrite = 1'b1;
                    retire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench tb_mc_ctrl_fsm
// Purpose: directed cycle-by-cycle check of every control output of
//   mc_ctrl_fsm (WAIT_MAX=4) against hand-computed control words.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_neg;
    logic       mem_ready;
    logic       iord, memread, memwrite, irwrite, pcwrite;
    logic       regdst, memtoreg, regwrite, alusrca, retire;
    logic [1:0] alusrcb, pcsrc, fault;
    logic [2:0] alucontrol;
    logic [18:0] obs;

    int total  = 0;
    int passed = 0;

    mc_ctrl_fsm #(
        .ALUCW    (3),
        .WAIT_MAX (4),
        .CNTW     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .retire     (retire),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: iord memread memwrite irwrite pcwrite regdst memtoreg
    // regwrite alusrca | alusrcb[2] alucontrol[3] pcsrc[2] retire fault[2]
    assign obs = {iord, memread, memwrite, irwrite, pcwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, alucontrol, pcsrc, retire, fault};

    localparam logic [18:0] C_ZERO    = '0;
    localparam logic [18:0] C_FETCH_R = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 2'b01, 3'd1, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_FETCH_W = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 3'd1, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_DECODE  = {9'b0, 2'b11, 3'd1, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_RWB     = {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] C_IEXEC   = {8'b0, 1'b1, 2'b10, 3'd1, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_IWB     = {7'b0, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] C_MEMADR  = C_IEXEC;
    localparam logic [18:0] C_MEMRD   = {1'b1, 1'b1, 7'b0, 2'b00, 3'd0, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_MEMWB   = {6'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] C_MEMWR_W = {1'b1, 1'b0, 1'b1, 6'b0, 2'b00, 3'd0, 2'b00, 1'b0, 2'b00};
    localparam logic [18:0] C_MEMWR_R = {1'b1, 1'b0, 1'b1, 6'b0, 2'b00, 3'd0, 2'b00, 1'b1, 2'b00};
    localparam logic [18:0] C_JUMP    = {4'b0, 1'b1, 4'b0, 2'b00, 3'd0, 2'b10, 1'b1, 2'b00};

    function automatic logic [18:0] c_rexec(input logic [2:0] aluc);
        return {8'b0, 1'b1, 2'b00, aluc, 2'b00, 1'b0, 2'b00};
    endfunction

    function automatic logic [18:0] c_branch(input logic pw);
        return {4'b0, pw, 3'b0, 1'b1, 2'b00, 3'd2, 2'b01, 1'b1, 2'b00};
    endfunction

    function automatic logic [18:0] c_fault(input logic [1:0] code);
        return {17'b0, code};
    endfunction

    // One clock cycle: let inputs settle, compare, then advance past the edge.
    task automatic cyc(input string tag, input logic [18:0] exp);
        #1;
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        op        = OP_RTYPE;
        funct     = FN_ADD;
        alu_zero  = 1'b0;
        alu_neg   = 1'b0;

        // Reset held 3 cycles: all outputs low
        cyc("rst_c0", C_ZERO);
        cyc("rst_c1", C_ZERO);
        cyc("rst_c2", C_ZERO);
        rst = 1'b0;
        cyc("init", C_ZERO);

        // add
        cyc("add_fetch", C_FETCH_R);
        cyc("add_decode", C_DECODE);
        cyc("add_rexec", c_rexec(3'd1));
        cyc("add_rwb", C_RWB);

        // sub
        funct = FN_SUB;
        cyc("sub_fetch", C_FETCH_R);
        cyc("sub_decode", C_DECODE);
        cyc("sub_rexec", c_rexec(3'd2));
        cyc("sub_rwb", C_RWB);

        // illegal funct: fault 01, no regwrite
        funct = 6'b000001;
        cyc("badfn_fetch", C_FETCH_R);
        cyc("badfn_decode", C_DECODE);
        cyc("badfn_rexec", c_rexec(3'd0));
        cyc("badfn_fault", c_fault(2'b01));
        cyc("badfn_hold", c_fault(2'b01));

        rst = 1'b1;
        cyc("rst_after_badfn", C_ZERO);
        rst = 1'b0;
        cyc("init2", C_ZERO);

        // lw with 3 cycles of mem_ready low in MEMRD: 8 cycles total
        op = OP_LW;
        cyc("lw_fetch", C_FETCH_R);
        cyc("lw_decode", C_DECODE);
        cyc("lw_memadr", C_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_memrd_w0", C_MEMRD);
        cyc("lw_memrd_w1", C_MEMRD);
        cyc("lw_memrd_w2", C_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd_rdy", C_MEMRD);
        cyc("lw_memwb", C_MEMWB);

        // addi
        op = OP_ADDI;
        cyc("addi_fetch", C_FETCH_R);
        cyc("addi_decode", C_DECODE);
        cyc("addi_iexec", C_IEXEC);
        cyc("addi_iwb", C_IWB);

        // sw, memory ready immediately
        op = OP_SW;
        cyc("sw_fetch", C_FETCH_R);
        cyc("sw_decode", C_DECODE);
        cyc("sw_memadr", C_MEMADR);
        cyc("sw_memwr", C_MEMWR_R);

        // branches
        op = OP_BEQ; alu_zero = 1'b1; alu_neg = 1'b0;
        cyc("beq_fetch", C_FETCH_R);
        cyc("beq_decode", C_DECODE);
        cyc("beq_taken", c_branch(1'b1));
        op = OP_BNE;
        cyc("bne_fetch", C_FETCH_R);
        cyc("bne_decode", C_DECODE);
        cyc("bne_not_taken", c_branch(1'b0));
        op = OP_BGTZ; alu_zero = 1'b0; alu_neg = 1'b0;
        cyc("bgtz_fetch", C_FETCH_R);
        cyc("bgtz_decode", C_DECODE);
        cyc("bgtz_taken", c_branch(1'b1));
        alu_neg = 1'b1;
        cyc("bgtzn_fetch", C_FETCH_R);
        cyc("bgtzn_decode", C_DECODE);
        cyc("bgtz_neg_not_taken", c_branch(1'b0));
        alu_neg = 1'b0;

        // jump
        op = OP_J;
        cyc("j_fetch", C_FETCH_R);
        cyc("j_decode", C_DECODE);
        cyc("j_jump", C_JUMP);

        // illegal opcode
        op = 6'b111111;
        cyc("badop_fetch", C_FETCH_R);
        cyc("badop_decode", C_DECODE);
        cyc("badop_fault", c_fault(2'b01));

        rst = 1'b1;
        cyc("rst_after_badop", C_ZERO);
        rst = 1'b0;
        cyc("init3", C_ZERO);

        // sw with mem_ready stuck low: timeout after 4 waiting cycles
        op = OP_SW;
        cyc("swto_fetch", C_FETCH_R);
        cyc("swto_decode", C_DECODE);
        cyc("swto_memadr", C_MEMADR);
        mem_ready = 1'b0;
        cyc("swto_w0", C_MEMWR_W);
        cyc("swto_w1", C_MEMWR_W);
        cyc("swto_w2", C_MEMWR_W);
        cyc("swto_w3", C_MEMWR_W);
        cyc("swto_fault", c_fault(2'b10));
        cyc("swto_hold", c_fault(2'b10));
        mem_ready = 1'b1;

        rst = 1'b1;
        cyc("rst_after_to", C_ZERO);
        rst = 1'b0;
        cyc("init4", C_ZERO);

        // sw with ready arriving in the 4th waiting cycle: no fault
        cyc("swok_fetch", C_FETCH_R);
        cyc("swok_decode", C_DECODE);
        cyc("swok_memadr", C_MEMADR);
        mem_ready = 1'b0;
        cyc("swok_w0", C_MEMWR_W);
        cyc("swok_w1", C_MEMWR_W);
        cyc("swok_w2", C_MEMWR_W);
        mem_ready = 1'b1;
        cyc("swok_rdy_last", C_MEMWR_R);
        cyc("swok_next_fetch", C_FETCH_R);

        // reset in the middle of MEMWR
        cyc("swrst_decode", C_DECODE);
        cyc("swrst_memadr", C_MEMADR);
        mem_ready = 1'b0;
        cyc("swrst_w0", C_MEMWR_W);
        rst = 1'b1;
        cyc("swrst_rst", C_ZERO);
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc("swrst_init", C_ZERO);
        cyc("swrst_fetch", C_FETCH_R);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
